// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared types and constants for the command-decoding controller.
// Holds the widths, command codes, FSM state encoding and the ALU operand addresses.
// No logic lives here; every consumer imports it with a wildcard import.
package sys_cmd_ctrl_pkg;

  // Default widths of the controller data path
  localparam int CC_DATA_W    = 8;
  localparam int CC_ADDR_BITS = 3;
  localparam int CC_FUN_W     = 4;

  // First byte of each command frame
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file entries that hold the ALU operands
  localparam logic [CC_ADDR_BITS:0] OPA_ADDR = (CC_ADDR_BITS + 1)'(0);
  localparam logic [CC_ADDR_BITS:0] OPB_ADDR = (CC_ADDR_BITS + 1)'(1);

  // Command FSM states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_OPA,
    ST_ALU_OPB,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LSB,
    ST_TX_MSB,
    ST_TX_RD
  } state_e;

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Bundle of the controller's RX, register-file, ALU and TX FIFO signals.
// master = the controller, slave = the surrounding RX/RF/ALU/TX blocks.
// Pure wiring; no storage and no added latency.
interface sys_cmd_ctrl_if
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CC_DATA_W,
  parameter int ADDR_BITS  = CC_ADDR_BITS,
  parameter int ALU_FUN_W  = CC_FUN_W
);

  // UART RX side
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  // Register file side
  logic                    RF_WR_EN;
  logic                    RF_RD_EN;
  logic [ADDR_BITS:0]      RF_ADDR;
  logic [DATA_WIDTH-1:0]   RF_WR_DATA;
  logic [DATA_WIDTH-1:0]   RF_RD_DATA;
  logic                    RF_RD_VLD;
  // ALU side
  logic                    ALU_EN;
  logic [ALU_FUN_W-1:0]    ALU_FUN;
  logic                    CLK_GATE_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  // TX FIFO side
  logic                    TX_FIFO_FULL;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD,
    output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA,
    input  RF_RD_DATA, RF_RD_VLD,
    output ALU_EN, ALU_FUN, CLK_GATE_EN,
    input  ALU_OUT, ALU_OUT_VLD,
    input  TX_FIFO_FULL,
    output TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD,
    input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA,
    output RF_RD_DATA, RF_RD_VLD,
    input  ALU_EN, ALU_FUN, CLK_GATE_EN,
    output ALU_OUT, ALU_OUT_VLD,
    output TX_FIFO_FULL,
    input  TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/sys_cmd_ctrl.sv
// Decodes framed RX byte commands into RF write/read strobes and ALU starts; returns bytes to TX.
// Latency: strobes register one cycle after the accepted byte; TX byte one cycle after data is ready.
// Backpressure: TX states hold (TX_D_VLD=0) while TX_FIFO_FULL; RX bytes in wait/TX states are dropped.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CC_DATA_W,
  parameter int ADDR_BITS  = CC_ADDR_BITS,
  parameter int ALU_FUN_W  = CC_FUN_W
) (
  input  logic            CLK,
  input  logic            RST,
  sys_cmd_ctrl_if.master  bus
);

  state_e                  state_q, state_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_BITS:0]      rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [ALU_FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                    clk_gate_en_q, clk_gate_en_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
  logic                    tx_d_vld_q, tx_d_vld_d;
  // Byte(s) waiting to go to TX: RF read data in the low byte, or the full ALU result
  logic [2*DATA_WIDTH-1:0] res_q, res_d;

  logic rx_vld;
  logic tx_ok;
  assign rx_vld = bus.RX_D_VLD;
  assign tx_ok  = !bus.TX_FIFO_FULL;

  // State register; reset aborts any partially received frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: frame parsing, wait-for-valid states and TX byte sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_vld) begin
          case (bus.RX_P_DATA)
            CMD_RF_WR:   state_d = ST_WR_ADDR;
            CMD_RF_RD:   state_d = ST_RD_ADDR;
            CMD_ALU_OP:  state_d = ST_ALU_OPA;
            CMD_ALU_NOP: state_d = ST_ALU_FUN;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR_ADDR:  if (rx_vld) state_d = ST_WR_DATA;
      ST_WR_DATA:  if (rx_vld) state_d = ST_IDLE;
      ST_RD_ADDR:  if (rx_vld) state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (bus.RF_RD_VLD) state_d = ST_TX_RD;
      ST_TX_RD:    if (tx_ok) state_d = ST_IDLE;
      ST_ALU_OPA:  if (rx_vld) state_d = ST_ALU_OPB;
      ST_ALU_OPB:  if (rx_vld) state_d = ST_ALU_FUN;
      ST_ALU_FUN:  if (rx_vld) state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: if (bus.ALU_OUT_VLD) state_d = ST_TX_LSB;
      ST_TX_LSB:   if (tx_ok) state_d = ST_TX_MSB;
      ST_TX_MSB:   if (tx_ok) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output next-values: strobes default low, address/data/function/result hold
  always_comb begin
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    alu_en_d      = 1'b0;
    tx_d_vld_d    = 1'b0;
    rf_addr_d     = rf_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    alu_fun_d     = alu_fun_q;
    clk_gate_en_d = clk_gate_en_q;
    tx_p_data_d   = tx_p_data_q;
    res_d         = res_q;
    case (state_q)
      ST_WR_ADDR: begin
        if (rx_vld) rf_addr_d = bus.RX_P_DATA[ADDR_BITS:0];
      end
      ST_WR_DATA: begin
        if (rx_vld) begin
          rf_wr_data_d = bus.RX_P_DATA;
          rf_wr_en_d   = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (rx_vld) begin
          rf_addr_d  = bus.RX_P_DATA[ADDR_BITS:0];
          rf_rd_en_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (bus.RF_RD_VLD) res_d = {{DATA_WIDTH{1'b0}}, bus.RF_RD_DATA};
      end
      ST_TX_RD: begin
        if (tx_ok) begin
          tx_p_data_d = res_q[DATA_WIDTH-1:0];
          tx_d_vld_d  = 1'b1;
        end
      end
      ST_ALU_OPA: begin
        if (rx_vld) begin
          rf_addr_d    = OPA_ADDR;
          rf_wr_data_d = bus.RX_P_DATA;
          rf_wr_en_d   = 1'b1;
        end
      end
      ST_ALU_OPB: begin
        if (rx_vld) begin
          rf_addr_d    = OPB_ADDR;
          rf_wr_data_d = bus.RX_P_DATA;
          rf_wr_en_d   = 1'b1;
        end
      end
      ST_ALU_FUN: begin
        if (rx_vld) begin
          alu_fun_d     = bus.RX_P_DATA[ALU_FUN_W-1:0];
          alu_en_d      = 1'b1;
          clk_gate_en_d = 1'b1;
        end
      end
      ST_ALU_WAIT: begin
        // Result captured; the ALU clock is no longer needed from the next cycle
        if (bus.ALU_OUT_VLD) begin
          res_d         = bus.ALU_OUT;
          clk_gate_en_d = 1'b0;
        end
      end
      ST_TX_LSB: begin
        if (tx_ok) begin
          tx_p_data_d = res_q[DATA_WIDTH-1:0];
          tx_d_vld_d  = 1'b1;
        end
      end
      ST_TX_MSB: begin
        if (tx_ok) begin
          tx_p_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_d_vld_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and data registers; every output resets to zero
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      res_q         <= '0;
    end else begin
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      res_q         <= res_d;
    end
  end

  assign bus.RF_WR_EN    = rf_wr_en_q;
  assign bus.RF_RD_EN    = rf_rd_en_q;
  assign bus.RF_ADDR     = rf_addr_q;
  assign bus.RF_WR_DATA  = rf_wr_data_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.CLK_GATE_EN = clk_gate_en_q;
  assign bus.TX_P_DATA   = tx_p_data_q;
  assign bus.TX_D_VLD    = tx_d_vld_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: directed frames followed by random frames against a frame-level model.
// The bench also plays register file, ALU and TX FIFO around the controller.
// Outputs are sampled half a cycle or 1 time unit after the rising edge.
module tb_sys_cmd_ctrl;
  import sys_cmd_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sys_cmd_ctrl_if bus ();

  sys_cmd_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Observed events (append-only, written by the monitor only)
  logic [11:0] wr_q  [$];
  logic [3:0]  rd_q  [$];
  logic [3:0]  alu_q [$];
  logic [7:0]  tx_q  [$];
  int n_wr = 0, n_rd = 0, n_alu = 0, n_tx = 0, excl_err = 0;
  // Environment register file, updated from observed writes
  logic [7:0] tb_rf [16] = '{default: 8'h00};

  // Model state and expected events
  logic [7:0]  ref_rf [16] = '{default: 8'h00};
  logic [11:0] exp_wr  [$];
  logic [3:0]  exp_rd  [$];
  logic [3:0]  exp_alu [$];
  logic [7:0]  exp_tx  [$];
  int wr_ptr = 0, rd_ptr = 0, alu_ptr = 0, tx_ptr = 0;

  // Monitor: record every strobe and flag illegal strobe overlaps
  always @(negedge CLK) begin
    if (bus.RF_WR_EN === 1'b1) begin
      wr_q.push_back({bus.RF_ADDR, bus.RF_WR_DATA});
      tb_rf[bus.RF_ADDR] = bus.RF_WR_DATA;
      n_wr++;
    end
    if (bus.RF_RD_EN === 1'b1) begin
      rd_q.push_back(bus.RF_ADDR);
      n_rd++;
    end
    if (bus.ALU_EN === 1'b1) begin
      alu_q.push_back(bus.ALU_FUN);
      n_alu++;
    end
    if (bus.TX_D_VLD === 1'b1) begin
      tx_q.push_back(bus.TX_P_DATA);
      n_tx++;
    end
    if (bus.RF_WR_EN === 1'b1 && bus.RF_RD_EN === 1'b1) excl_err++;
    if (bus.RF_WR_EN === 1'b1 && bus.ALU_EN === 1'b1)   excl_err++;
  end

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      default: return {a, b} ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {3'b000, bus.RF_WR_EN, bus.RF_RD_EN, bus.RF_ADDR, bus.RF_WR_DATA, bus.ALU_EN,
            bus.ALU_FUN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge CLK);
    @(posedge CLK); #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'($urandom);
  endtask

  // Wait until an event counter reaches target; 0=wr 1=rd 2=alu 3=tx
  task automatic wait_evt(input int which, input int target, output bit ok);
    int budget = 200;
    int got;
    ok = 1'b0;
    while (budget > 0) begin
      case (which)
        0:       got = n_wr;
        1:       got = n_rd;
        2:       got = n_alu;
        default: got = n_tx;
      endcase
      if (got >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK); #1;
      budget--;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_wr_cnt"}, wr_q.size() - wr_ptr, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wr_ptr + i < wr_q.size(); i++)
      check({tag, "_wr"}, wr_q[wr_ptr+i], exp_wr[i]);
    check({tag, "_rd_cnt"}, rd_q.size() - rd_ptr, exp_rd.size());
    for (int i = 0; i < exp_rd.size() && rd_ptr + i < rd_q.size(); i++)
      check({tag, "_rd"}, rd_q[rd_ptr+i], exp_rd[i]);
    check({tag, "_alu_cnt"}, alu_q.size() - alu_ptr, exp_alu.size());
    for (int i = 0; i < exp_alu.size() && alu_ptr + i < alu_q.size(); i++)
      check({tag, "_alu_fun"}, alu_q[alu_ptr+i], exp_alu[i]);
    check({tag, "_tx_cnt"}, tx_q.size() - tx_ptr, exp_tx.size());
    for (int i = 0; i < exp_tx.size() && tx_ptr + i < tx_q.size(); i++)
      check({tag, "_tx"}, tx_q[tx_ptr+i], exp_tx[i]);
    wr_ptr = wr_q.size(); rd_ptr = rd_q.size(); alu_ptr = alu_q.size(); tx_ptr = tx_q.size();
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
  endtask

  task automatic do_write(input logic [7:0] addr_b, input logic [7:0] data);
    send_byte(CMD_RF_WR);
    send_byte(addr_b);
    send_byte(data);
    exp_wr.push_back({addr_b[3:0], data});
    ref_rf[addr_b[3:0]] = data;
    idle(3);
    check("wr_addr_hold", bus.RF_ADDR, addr_b[3:0]);
    compare_all("write");
  endtask

  task automatic do_read(input logic [7:0] addr_b, input int full_cycles);
    int base_rd = n_rd;
    int base_tx = n_tx;
    bit ok;
    bus.TX_FIFO_FULL = (full_cycles > 0);
    send_byte(CMD_RF_RD);
    send_byte(addr_b);
    exp_rd.push_back(addr_b[3:0]);
    exp_tx.push_back(ref_rf[addr_b[3:0]]);
    wait_evt(1, base_rd + 1, ok);
    check("rd_strobe_seen", ok, 1);
    @(posedge CLK); #1;
    bus.RF_RD_DATA = tb_rf[bus.RF_ADDR];
    bus.RF_RD_VLD  = 1'b1;
    @(posedge CLK); #1;
    bus.RF_RD_VLD  = 1'b0;
    bus.RF_RD_DATA = 8'($urandom);
    if (full_cycles > 0) begin
      repeat (full_cycles) @(posedge CLK);
      #1;
      check("rd_tx_held_while_full", n_tx - base_tx, 0);
      bus.TX_FIFO_FULL = 1'b0;
    end
    wait_evt(3, base_tx + 1, ok);
    check("rd_tx_seen", ok, 1);
    idle(2);
    compare_all("read");
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fun_b, input int full_cycles);
    int base_alu = n_alu;
    int base_tx  = n_tx;
    logic [15:0] res;
    bit ok;
    if (with_ops) begin
      send_byte(CMD_ALU_OP);
      send_byte(a);
      send_byte(b);
      ref_rf[0] = a;
      ref_rf[1] = b;
      exp_wr.push_back({4'h0, a});
      exp_wr.push_back({4'h1, b});
    end else begin
      send_byte(CMD_ALU_NOP);
    end
    send_byte(fun_b);
    exp_alu.push_back(fun_b[3:0]);
    res = alu_fn(ref_rf[0], ref_rf[1], fun_b[3:0]);
    exp_tx.push_back(res[7:0]);
    exp_tx.push_back(res[15:8]);
    wait_evt(2, base_alu + 1, ok);
    check("alu_en_seen", ok, 1);
    check("clk_gate_busy", bus.CLK_GATE_EN, 1);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
    @(posedge CLK); #1;
    bus.ALU_OUT      = alu_fn(tb_rf[0], tb_rf[1], bus.ALU_FUN);
    bus.ALU_OUT_VLD  = 1'b1;
    bus.TX_FIFO_FULL = (full_cycles > 0);
    @(posedge CLK); #1;
    bus.ALU_OUT_VLD  = 1'b0;
    bus.ALU_OUT      = 16'($urandom);
    if (full_cycles > 0) begin
      repeat (full_cycles) @(posedge CLK);
      #1;
      check("alu_tx_held_while_full", n_tx - base_tx, 0);
      bus.TX_FIFO_FULL = 1'b0;
    end
    wait_evt(3, base_tx + 2, ok);
    check("alu_tx_seen", ok, 1);
    idle(2);
    check("clk_gate_released", bus.CLK_GATE_EN, 0);
    check("alu_fun_hold", bus.ALU_FUN, fun_b[3:0]);
    compare_all("alu");
  endtask

  initial begin
    logic [7:0] r1, r2, r3;
    bus.RX_P_DATA    = 8'h00;
    bus.RX_D_VLD     = 1'b0;
    bus.RF_RD_DATA   = 8'h00;
    bus.RF_RD_VLD    = 1'b0;
    bus.ALU_OUT      = 16'h0000;
    bus.ALU_OUT_VLD  = 1'b0;
    bus.TX_FIFO_FULL = 1'b0;

    // Power-on reset
    @(negedge CLK);
    check("reset_outputs", outs(), 0);
    idle(2);
    RST = 1'b1;

    // Reset in the middle of a write frame aborts it
    send_byte(CMD_RF_WR);
    send_byte(8'h05);
    idle(1);
    RST = 1'b0;
    @(negedge CLK);
    check("midcmd_reset_outputs", outs(), 0);
    idle(2);
    RST = 1'b1;
    send_byte(8'h3C);
    idle(3);
    compare_all("after_reset");
    do_write(8'h05, 8'h3C);

    // Read with TX FIFO full for 4 cycles
    do_write(8'h02, 8'h81);
    do_read(8'h02, 4);

    // ALU add with operands, then ALU multiply on the stored operands
    do_alu(1'b1, 8'h0A, 8'h03, 8'h00, 0);
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 2);

    // Non-command byte ignored; upper address bits truncated
    send_byte(8'h55);
    do_write(8'h1F, 8'h77);

    // Random frames
    for (int t = 0; t < 25; t++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      case ($urandom_range(0, 4))
        0: do_write(r1, r2);
        1: do_read(r1, int'($urandom_range(0, 3)));
        2: do_alu(1'b1, r1, r2, r3, int'($urandom_range(0, 2)));
        3: do_alu(1'b0, r1, r2, r3, int'($urandom_range(0, 2)));
        default: begin
          while (r1 == CMD_RF_WR || r1 == CMD_RF_RD || r1 == CMD_ALU_OP || r1 == CMD_ALU_NOP)
            r1 = 8'($urandom);
          send_byte(r1);
          idle(3);
          compare_all("junk");
        end
      endcase
    end

    check("strobe_exclusive", excl_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
Command-decoding controller between the UART RX/TX path and the register file / ALU, in the RX-clock-independent REF_CLK domain. Parses framed byte commands from the synchronised UART RX data bus and issues register-file write and read strobes. Starts ALU operations on operands held in register-file entries 0/1. Returns read data and ALU results as bytes to the TX FIFO.

Parameters:
DATA_WIDTH, 8, width of command/data bytes and register-file words
ADDR_BITS, 3, register-file address port is ADDR_BITS+1 bits wide (16 entries)
ALU_FUN_W, 4, ALU function code width

Ports:
CLK  input  1  REF_CLK domain clock
RST  input  1  asynchronous, active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte (already synchronised)
RX_D_VLD  input  1  one-cycle pulse per received byte
RF_WR_EN  output  1  register-file write strobe
RF_RD_EN  output  1  register-file read strobe
RF_ADDR  output  ADDR_BITS+1  register-file address
RF_WR_DATA  output  DATA_WIDTH  register-file write data
RF_RD_DATA  input  DATA_WIDTH  register-file read data
RF_RD_VLD  input  1  read data valid, one cycle after RF_RD_EN
ALU_EN  output  1  one-cycle ALU start
ALU_FUN  output  ALU_FUN_W  ALU function code
CLK_GATE_EN  output  1  ALU clock-gate enable
ALU_OUT  input  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  input  1  ALU result valid pulse
TX_FIFO_FULL  input  1  TX FIFO cannot accept
TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  output  1  one-cycle TX FIFO write

Behaviour:
- All outputs registered. Reset value 0 for every output; FSM to IDLE. Reset mid-command aborts it with no partial strobes.
- Command codes, first byte of a frame:
  - 0xAA = RF write: addr, data.
  - 0xBB = RF read: addr.
  - 0xCC = ALU with operands: A, B, fun.
  - 0xDD = ALU without operands: fun.
  - Any other first byte is ignored; FSM stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB, TX_RD.
- Field capture:
  - Address: RF_ADDR = RX_P_DATA[ADDR_BITS:0]; upper bits are ignored.
  - ALU function: ALU_FUN = RX_P_DATA[ALU_FUN_W-1:0].
- WR_ADDR: on RX_D_VLD, latch the address, go to WR_DATA.
- WR_DATA: on RX_D_VLD, drive RF_WR_DATA and RF_WR_EN=1 for exactly one cycle, go to IDLE.
- RD_ADDR: on RX_D_VLD, RF_RD_EN=1 for one cycle, go to RD_WAIT.
- RD_WAIT: on RF_RD_VLD, latch RF_RD_DATA, go to TX_RD.
- TX_RD: when !TX_FIFO_FULL, TX_D_VLD=1 for one cycle with the latched byte, go to IDLE. While full, hold with TX_D_VLD=0.
- ALU_OPA: on RX_D_VLD, write the byte to RF addr 0 (one-cycle RF_WR_EN), go to ALU_OPB.
- ALU_OPB: on RX_D_VLD, write the byte to RF addr 1, go to ALU_FUN.
- ALU_FUN: on RX_D_VLD, latch ALU_FUN, ALU_EN=1 for one cycle, CLK_GATE_EN=1, go to ALU_WAIT.
- CLK_GATE_EN stays high from ALU_FUN acceptance until the cycle after ALU_OUT_VLD, then drops to 0.
- ALU_WAIT: on ALU_OUT_VLD, latch the full 16-bit ALU_OUT, go to TX_LSB.
- TX_LSB / TX_MSB: send ALU_OUT[7:0] then ALU_OUT[15:8]. Each byte is one TX_D_VLD pulse, gated by !TX_FIFO_FULL. Then go to IDLE.
- Strobe exclusivity:
  - RF_WR_EN and RF_RD_EN are never high in the same cycle.
  - ALU_EN never coincides with RF_WR_EN.
- Bytes arriving in RD_WAIT, ALU_WAIT or TX_* states are dropped; no queuing.
- No timeout: the wait states hold until the valid input arrives.
- ALU_FUN holds its last value between operations.
- RF_ADDR and RF_WR_DATA hold their last values when strobes are low.

Decomposition:
- Shared package holds:
  - the command-code constants (CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD);
  - the state encoding;
  - the operand addresses OPA_ADDR=0, OPB_ADDR=1.
- Single module; no sub-module. The TX byte sender is part of the FSM.

Test Plan:
- Reset with RST=0 mid-command (after 0xAA,0x05) -> all outputs 0, FSM IDLE. A subsequent 0xAA,0x05,0x3C completes normally.
- RX 0xAA,0x05,0x3C -> exactly one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C. RF_RD_EN stays 0 throughout.
- RX 0xBB,0x02; RF returns 0x81 one cycle after RF_RD_EN; TX_FIFO_FULL held 1 for 4 cycles -> TX_D_VLD pulses once with 0x81, only after FULL drops.
- RX 0xCC,0x0A,0x03,0x00 (add):
  - expect RF writes addr0=0x0A, then addr1=0x03, then one ALU_EN with ALU_FUN=0;
  - model ALU_OUT=0x000D with ALU_OUT_VLD -> TX bytes 0x0D then 0x00;
  - CLK_GATE_EN low again after the result.
- RX 0xDD,0x02 with ALU_OUT=0x001E -> no RF_WR_EN, one ALU_EN with ALU_FUN=2, TX bytes 0x1E, 0x00.
- RX 0x55 then 0xAA,0x1F,0x77 -> 0x55 ignored. Write goes to RF_ADDR=0xF (upper address bits truncated) with data 0x77.
